// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the ROM/RAM pair between the 6502 core and a
// debug/loader master. Alternating-priority grant, ROM/RAM select latched
// at grant time, fixed IDLE -> ACCESS x MEM_LATENCY -> DONE sequence.
// Optional build macro: MEM_BUS_ARB_ROM_WRITE_EN (debug port may write ROM).
module mem_bus_arbiter #(
   parameter int MEM_LATENCY = 1,    // 1..4
   parameter bit DBG_FIRST   = 1'b0  // first simultaneous-request winner
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_ack,
   output logic        cpu_rdy,
   input  logic        dbg_req,
   input  logic [15:0] dbg_addr,
   input  logic        dbg_we,
   input  logic [7:0]  dbg_wdata,
   output logic [7:0]  dbg_rdata,
   output logic        dbg_ack,
   output logic [14:0] mem_addr,
   output logic        rom_cs,
   output logic        ram_cs,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  rom_rdata,
   input  logic [7:0]  ram_rdata,
   output logic        wr_err
);

`ifdef MEM_BUS_ARB_ROM_WRITE_EN
   localparam bit DBG_ROM_WR = 1'b1;
`else
   localparam bit DBG_ROM_WR = 1'b0;
`endif

   localparam logic [1:0] CNT_LAST = 2'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        cpu_pend_q, cpu_pend_d;
   logic        last_dbg_q, last_dbg_d;   // 1 = debug won the last grant
   logic        gnt_dbg_q, gnt_dbg_d;     // master owning the current access
   logic        sel_q, sel_d;             // 1 = ROM, frozen for the whole access
   logic [14:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic        drop_q, drop_d;           // write suppressed (ROM protection)
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;
   logic [7:0]  dbg_rdata_q, dbg_rdata_d;
   logic        wr_err_q, wr_err_d;

   logic        cpu_want, pick_dbg, in_access, done;

   // A CPU pulse arriving in IDLE is granted the same cycle; otherwise it waits in cpu_pend.
   assign cpu_want  = cpu_pend_q | cpu_req;
   assign pick_dbg  = dbg_req & (~cpu_want | ~last_dbg_q);
   assign in_access = (state_q == S_ACCESS);
   assign done      = (state_q == S_DONE);

   // State register and all latched access context
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cpu_pend_q  <= 1'b0;
         last_dbg_q  <= ~DBG_FIRST;
         gnt_dbg_q   <= 1'b0;
         sel_q       <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         drop_q      <= 1'b0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cpu_pend_q  <= cpu_pend_d;
         last_dbg_q  <= last_dbg_d;
         gnt_dbg_q   <= gnt_dbg_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         drop_q      <= drop_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         wr_err_q    <= wr_err_d;
      end
   end

   // Next-state: grant in IDLE, count ACCESS cycles, capture read data on the last one
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_dbg_d  = last_dbg_q;
      gnt_dbg_d   = gnt_dbg_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      we_d        = we_q;
      drop_d      = drop_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      wr_err_d    = wr_err_q;
      cpu_pend_d  = cpu_pend_q;

      if (cpu_ack)
         cpu_pend_d = 1'b0;
      else if (cpu_req)
         cpu_pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (cpu_want | dbg_req) begin
               gnt_dbg_d  = pick_dbg;
               last_dbg_d = pick_dbg;
               addr_d     = pick_dbg ? dbg_addr[14:0] : cpu_addr[14:0];
               sel_d      = pick_dbg ? dbg_addr[15]   : cpu_addr[15];
               we_d       = pick_dbg ? dbg_we         : cpu_we;
               wdata_d    = pick_dbg ? dbg_wdata      : cpu_wdata;
               drop_d     = we_d & sel_d & (~pick_dbg | ~DBG_ROM_WR);
               if (drop_d)
                  wr_err_d = 1'b1;
               cnt_d   = '0;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               if (!we_q) begin
                  if (gnt_dbg_q) dbg_rdata_d = sel_q ? rom_rdata : ram_rdata;
                  else           cpu_rdata_d = sel_q ? rom_rdata : ram_rdata;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Memory-side strobes: cs for the whole access, write strobe in its first cycle only
   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      rom_cs    = in_access & sel_q;
      ram_cs    = in_access & ~sel_q;
      mem_we    = in_access & (cnt_q == 2'd0) & we_q & ~drop_q;
      cpu_ack   = done & ~gnt_dbg_q;
      dbg_ack   = done & gnt_dbg_q;
      cpu_rdy   = ~cpu_pend_q | cpu_ack;
      cpu_rdata = cpu_rdata_q;
      dbg_rdata = dbg_rdata_q;
      wr_err    = wr_err_q;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (MEM_LATENCY=1, DBG_FIRST=0).
module tb_mem_bus_arbiter;
   localparam int ML = 1;

   logic        clk = 1'b0, reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
   logic [15:0] cpu_addr = '0, dbg_addr = '0;
   logic [7:0]  cpu_wdata = '0, dbg_wdata = '0, rom_d = '0, ram_d = '0;
   logic [7:0]  cpu_rdata, dbg_rdata, mem_wdata;
   logic        cpu_ack, cpu_rdy, dbg_ack, rom_cs, ram_cs, mem_we, wr_err;
   logic [14:0] mem_addr;

   int n_cmp = 0, n_bad = 0;

   mem_bus_arbiter #(.MEM_LATENCY(ML), .DBG_FIRST(1'b0)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_rdy(cpu_rdy),
      .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_we(dbg_we), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_addr(mem_addr), .rom_cs(rom_cs), .ram_cs(ram_cs), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .rom_rdata(rom_d), .ram_rdata(ram_d), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One transaction from a single master; sampled on falling edges.
   task automatic run_txn(input bit is_dbg, input logic [15:0] a, input bit w,
                          input logic [7:0] wd, output int ack_k, output int rom_n,
                          output int ram_n, output int we_n, output int bad_n);
      @(negedge clk);
      ack_k = -1; rom_n = 0; ram_n = 0; we_n = 0; bad_n = 0;
      if (is_dbg) begin
         dbg_addr = a; dbg_we = w; dbg_wdata = wd; dbg_req = 1'b1;
      end else begin
         cpu_addr = a; cpu_we = w; cpu_wdata = wd; cpu_req = 1'b1;
      end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         cpu_req = 1'b0;
         if (rom_cs) rom_n++;
         if (ram_cs) ram_n++;
         if ((rom_cs | ram_cs) && mem_addr != a[14:0]) bad_n++;
         if (mem_we) begin
            we_n++;
            if (mem_wdata != wd) bad_n++;
         end
         // cpu_rdy low while own access pending, high in the ack cycle
         if (cpu_rdy != (is_dbg ? 1'b1 : cpu_ack)) bad_n++;
         if (is_dbg ? dbg_ack : cpu_ack) begin
            ack_k = k;
            break;
         end
      end
      dbg_req = 1'b0;
   endtask

   // Both masters request in the same cycle; returns ack cycle of each.
   task automatic run_both(output int cpu_k, output int dbg_k);
      @(negedge clk);
      cpu_k = -1; dbg_k = -1;
      cpu_we = 1'b0; dbg_we = 1'b0;
      cpu_req = 1'b1; dbg_req = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         cpu_req = 1'b0;
         if (cpu_ack) cpu_k = k;
         if (dbg_ack) begin
            dbg_k = k;
            dbg_req = 1'b0;
         end
         if (cpu_k > 0 && dbg_k > 0) break;
      end
      dbg_req = 1'b0;
   endtask

   typedef struct {
      bit          is_dbg;
      logic [15:0] addr;
      bit          we;
      logic [7:0]  wdata, rom, ram;
      int          e_rom, e_ram, e_we;
      logic [7:0]  e_rd;   // expected rdata of that master afterwards
      bit          e_err;
   } vec_t;

   vec_t vt[9];
   logic [7:0] m_cpu, m_dbg;
   int ak, rn, wn, mn, bn, ck, dk;

   initial begin
      vt[0] = '{0, 16'h8003, 0, 8'h00, 8'hA9, 8'h33, 1, 0, 0, 8'hA9, 0};
      vt[1] = '{1, 16'h0123, 0, 8'h00, 8'h44, 8'h5C, 0, 1, 0, 8'h5C, 0};
      vt[2] = '{1, 16'h0200, 1, 8'h5A, 8'h44, 8'h00, 0, 1, 1, 8'h5C, 0};
      vt[3] = '{0, 16'h0200, 0, 8'h00, 8'h00, 8'h5A, 0, 1, 0, 8'h5A, 0};
      vt[4] = '{0, 16'h1234, 1, 8'h77, 8'h00, 8'h00, 0, 1, 1, 8'h5A, 0};
`ifdef MEM_BUS_ARB_ROM_WRITE_EN
      vt[5] = '{1, 16'h9000, 1, 8'h11, 8'h00, 8'h00, 1, 0, 1, 8'h5C, 0};
`else
      vt[5] = '{1, 16'h9000, 1, 8'h11, 8'h00, 8'h00, 1, 0, 0, 8'h5C, 1};
`endif
      vt[6] = '{0, 16'hC000, 1, 8'h12, 8'h00, 8'h00, 1, 0, 0, 8'h5A, 1};
      vt[7] = '{1, 16'hFFFF, 0, 8'h00, 8'hEE, 8'h01, 1, 0, 0, 8'hEE, 1};
      vt[8] = '{0, 16'h7FFF, 0, 8'h00, 8'h02, 8'h3C, 0, 1, 0, 8'h3C, 1};

      // Reset state
      do_reset();
      chk("rst_cpu_rdy", cpu_rdy, 1);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_dbg_ack", dbg_ack, 0);
      chk("rst_cs", {rom_cs, ram_cs, mem_we}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
      chk("rst_wr_err", wr_err, 0);

      // Simultaneous requests right after reset: CPU first, debug 3 cycles later
      cpu_addr = 16'h0005; dbg_addr = 16'h8006; rom_d = 8'h61; ram_d = 8'h62;
      run_both(ck, dk);
      chk("both0_cpu_lat", ck, ML + 1);
      chk("both0_dbg_lat", dk, ML + 1 + 3);
      chk("both0_cpu_rd", cpu_rdata, 8'h62);
      chk("both0_dbg_rd", dbg_rdata, 8'h61);
      m_cpu = 8'h62; m_dbg = 8'h61;

      // Table-driven single-master transactions
      foreach (vt[i]) begin
         rom_d = vt[i].rom; ram_d = vt[i].ram;
         run_txn(vt[i].is_dbg, vt[i].addr, vt[i].we, vt[i].wdata, ak, rn, mn, wn, bn);
         if (vt[i].is_dbg) m_dbg = vt[i].e_rd; else m_cpu = vt[i].e_rd;
         chk($sformatf("v%0d_ack_lat", i), ak, ML + 1);
         chk($sformatf("v%0d_rom_cs", i), rn, vt[i].e_rom * ML);
         chk($sformatf("v%0d_ram_cs", i), mn, vt[i].e_ram * ML);
         chk($sformatf("v%0d_mem_we", i), wn, vt[i].e_we);
         chk($sformatf("v%0d_addr_wd_rdy", i), bn, 0);
         chk($sformatf("v%0d_cpu_rd", i), cpu_rdata, m_cpu);
         chk($sformatf("v%0d_dbg_rd", i), dbg_rdata, m_dbg);
         chk($sformatf("v%0d_wr_err", i), wr_err, vt[i].e_err);
      end

      // Alternation: last grant CPU, so a simultaneous pair goes to debug first
      rom_d = 8'h00; ram_d = 8'h10;
      run_txn(0, 16'h0040, 0, 8'h00, ak, rn, mn, wn, bn);
      chk("alt_setup_lat", ak, ML + 1);
      cpu_addr = 16'h0041; dbg_addr = 16'h8042; rom_d = 8'h71; ram_d = 8'h72;
      run_both(ck, dk);
      chk("alt_dbg_lat", dk, ML + 1);
      chk("alt_cpu_lat", ck, ML + 1 + 3);
      chk("alt_cpu_rd", cpu_rdata, 8'h72);
      chk("alt_dbg_rd", dbg_rdata, 8'h71);

      // CPU address drifts during ACCESS: select and address stay latched
      @(negedge clk);
      cpu_addr = 16'h8000; cpu_we = 1'b0; cpu_req = 1'b1; rom_d = 8'hB1; ram_d = 8'h22;
      @(posedge clk);
      #1 cpu_addr = 16'h0010; cpu_req = 1'b0;
      ak = -1; mn = 0; bn = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (ram_cs) mn++;
         if (rom_cs && mem_addr != 15'h0000) bn++;
         if (cpu_ack) begin ak = k; break; end
      end
      chk("drift_ack_lat", ak, ML + 1);
      chk("drift_ram_cs", mn, 0);
      chk("drift_addr", bn, 0);
      chk("drift_cpu_rd", cpu_rdata, 8'hB1);

      // Reset in the middle of a CPU read: access abandoned, nothing acked
      @(negedge clk);
      cpu_addr = 16'h8001; cpu_req = 1'b1; rom_d = 8'h99;
      @(negedge clk);
      cpu_req = 1'b0;
      chk("mid_in_access", {rom_cs, cpu_rdy}, 2'b10);
      reset = 1'b1;
      #1;
      chk("mid_rst_cs", rom_cs, 0);
      chk("mid_rst_rdy", cpu_rdy, 1);
      chk("mid_rst_rd", cpu_rdata, 0);
      chk("mid_rst_err", wr_err, 0);
      @(negedge clk);
      reset = 1'b0;
      wn = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (cpu_ack | rom_cs | ram_cs) wn++;
      end
      chk("mid_no_ack", wn, 0);
      rom_d = 8'h00; ram_d = 8'h4D;
      run_txn(0, 16'h0333, 0, 8'h00, ak, rn, mn, wn, bn);
      chk("post_rst_lat", ak, ML + 1);
      chk("post_rst_rd", cpu_rdata, 8'h4D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
